mem_stage: RTL

- Memory-access stage. Sits directly downstream of the EX stage, behind the EX/MEM pipeline register, and feeds the MEM/WB register.
- Non-memory ops pass their EX result straight through.
- Loads and stores are issued to the data bus over a req/ack handshake. The pipeline is stalled until the access completes.
- Loads are lane-extracted and extended; stores are lane-replicated with byte enables.

---
 rtl/mem_stage_pkg.sv | 31 +++
 rtl/mem_data_align.sv | 30 +++
 rtl/mem_stage.sv | 100 ++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: op codes, FSM states and op classifiers shared by mem_stage and mem_data_align
package mem_stage_pkg;
  localparam logic [7:0] EXE_OR_OP  = 8'b00100101;
  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
  typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_DONE} mem_state_t;
  function automatic logic is_load(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction
  function automatic logic is_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction
  function automatic logic is_byte(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP};
  endfunction
  function automatic logic is_half(input logic [7:0] op);
    return op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
  endfunction
  function automatic logic is_word(input logic [7:0] op);
    return op inside {EXE_LW_OP, EXE_SW_OP};
  endfunction
  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] lo);
    return (is_half(op) && lo[0]) || (is_word(op) && lo != 2'b00);
  endfunction
endpackage

// File: rtl/mem_data_align.sv
// mem_data_align: byte enables, store lane replication and load lane extraction/extension (aluop, addr_lo, st_in, rdata -> be, st_data, ld_data)
module mem_data_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_in,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] st_data,
  output logic [31:0] ld_data
);
  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    be = is_byte(aluop) ? 4'b0001 << addr_lo :
         is_half(aluop) ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
         is_word(aluop) ? 4'b1111 : 4'b0000;
    st_data = is_byte(aluop) ? {4{st_in[7:0]}} :
              is_half(aluop) ? {2{st_in[15:0]}} : st_in;
    shifted = rdata >> {addr_lo, 3'b000};
    b = shifted[7:0];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    ld_data = aluop == EXE_LB_OP  ? {{24{b[7]}}, b} :
              aluop == EXE_LBU_OP ? {24'b0, b} :
              aluop == EXE_LH_OP  ? {{16{h[15]}}, h} :
              aluop == EXE_LHU_OP ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage, EX/MEM inputs -> MEM/WB outputs, req/ack data bus FSM with stallreq_o; MEM_ALIGN_CHECK_EN adds misalign_o
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [4:0]        waddr_i,
  input  logic              we_i,
  input  logic [31:0]       wdata_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_data_i,
  output logic [4:0]        waddr_o,
  output logic              we_o,
  output logic [31:0]       wdata_o,
  output logic              stallreq_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misalign_o
`endif
);
  mem_state_t        state;
  logic [3:0]        be, be_r;
  logic [31:0]       st_data, ld_data, ld_buf;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [4:0]        waddr_r;
  logic              bwe_r, ld_r, we_r, is_mem, misalign, start, pass;
  mem_data_align u_align (
    .aluop   (aluop_i),
    .addr_lo (mem_addr_i[1:0]),
    .st_in   (mem_data_i),
    .rdata   (mem_rdata_i),
    .be      (be),
    .st_data (st_data),
    .ld_data (ld_data)
  );
  assign is_mem = is_load(aluop_i) || is_store(aluop_i);
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign   = state == MEM_IDLE && is_mem && is_misaligned(aluop_i, mem_addr_i[1:0]);
  assign misalign_o = rst && misalign;
`else
  assign misalign = 1'b0;
`endif
  assign start = state == MEM_IDLE && is_mem && !misalign;
  assign pass  = state == MEM_IDLE && !is_mem;
  // Load lane extraction happens at ack time: EX/MEM holds aluop_i/mem_addr_i throughout REQ.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= MEM_IDLE;
      ld_buf  <= '0;
      addr_r  <= '0;
      be_r    <= '0;
      wdata_r <= '0;
      bwe_r   <= 1'b0;
      ld_r    <= 1'b0;
      we_r    <= 1'b0;
      waddr_r <= '0;
    end else begin
      unique case (state)
        MEM_IDLE: if (start) begin
          state   <= MEM_REQ;
          addr_r  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
          be_r    <= be;
          wdata_r <= is_store(aluop_i) ? st_data : '0;
          bwe_r   <= is_store(aluop_i);
          ld_r    <= is_load(aluop_i);
          we_r    <= we_i;
          waddr_r <= waddr_i;
        end
        MEM_REQ: if (mem_ack_i) begin
          ld_buf <= ld_data;
          state  <= MEM_DONE;
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end
  always_comb begin
    waddr_o     = !rst ? '0 : pass ? waddr_i : state == MEM_DONE ? waddr_r : '0;
    we_o        = rst && (pass ? we_i : state == MEM_DONE && ld_r && we_r);
    wdata_o     = !rst ? '0 : pass ? wdata_i : (state == MEM_DONE && ld_r) ? ld_buf : '0;
    stallreq_o  = rst && (start || state == MEM_REQ);
    mem_req_o   = rst && state == MEM_REQ;
    mem_we_o    = rst && bwe_r;
    mem_addr_o  = rst ? addr_r : '0;
    mem_be_o    = rst ? be_r : '0;
    mem_wdata_o = rst ? wdata_r : '0;
  end
endmodule
